wb_io_responder: RTL



---
 rtl/wb_io_responder_pkg.sv | 22 ++
 rtl/wb_io_responder_if.sv | 21 ++
 rtl/wb_io_responder_io_sync_edge.sv | 51 +++++
 rtl/wb_io_responder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/wb_io_responder_pkg.sv
// Shared constants and types for the Wishbone GPIO responder (wb_io_responder).
package wb_io_pkg;

    localparam int unsigned IO_W_DEF = 5;
    localparam int unsigned DW       = 32;

    localparam logic [7:0] OFF_DATA_OUT   = 8'h00;
    localparam logic [7:0] OFF_OEB        = 8'h04;
    localparam logic [7:0] OFF_DATA_IN    = 8'h08;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h0C;
    localparam logic [7:0] OFF_IRQ_MASK   = 8'h10;
    localparam logic [7:0] OFF_EDGE_SEL   = 8'h14;

    localparam logic [DW-1:0] DATA_OUT_RST = 32'h0000_0000;
    localparam logic [DW-1:0] OEB_RST      = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/wb_io_responder_if.sv
// Wishbone classic slave-side bus bundle for wb_io_responder.
interface wb_io_responder_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/wb_io_responder_io_sync_edge.sv
// Pad-input synchronizer; with IO_EDGE_IRQ_EN also a per-pin rise/fall edge detector.
module io_sync_edge
    import wb_io_pkg::*;
#(
    parameter int unsigned IO_W        = IO_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [IO_W-1:0] i_async,
`ifdef IO_EDGE_IRQ_EN
    input  logic [IO_W-1:0] i_edge_sel,
    output logic [IO_W-1:0] o_edge,
`endif
    output logic [IO_W-1:0] o_sync
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("io_sync_edge: SYNC_STAGES must be at least 2");
    end

    logic [IO_W-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_async;
            for (int k = 1; k < int'(SYNC_STAGES); k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];

`ifdef IO_EDGE_IRQ_EN
    logic [IO_W-1:0] r_prev;
    logic [IO_W-1:0] w_rise;
    logic [IO_W-1:0] w_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= '0;
        else       r_prev <= o_sync;
    end

    // EDGE_SEL bit 0 selects rising, 1 selects falling
    assign w_rise = o_sync & ~r_prev;
    assign w_fall = ~o_sync & r_prev;
    assign o_edge = (w_rise & ~i_edge_sel) | (w_fall & i_edge_sel);
`endif

endmodule

// File: rtl/wb_io_responder.sv
// Wishbone classic GPIO responder for io[37:33]; IO_EDGE_IRQ_EN adds edge interrupt registers.
module wb_io_responder
    import wb_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned IO_W        = IO_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_io_responder_if.slave    wbs,
    input  logic [IO_W-1:0]     io_in,
    output logic [IO_W-1:0]     io_out,
    output logic [IO_W-1:0]     io_oeb,
    output logic [2:0]          user_irq
);

    bus_state_e      r_state;
    logic            r_ack;
    logic [DW-1:0]   r_dat;
    logic [IO_W-1:0] r_data_out;
    logic [IO_W-1:0] r_oeb;
    logic [IO_W-1:0] w_sync;
    logic [DW-1:0]   w_rd_data;
    logic [IO_W-1:0] w_wdata;
    logic [7:0]      w_off;
    logic            w_sel;
    logic            w_take;
    logic            w_wr;
    logic            w_unused;

`ifdef IO_EDGE_IRQ_EN
    logic [IO_W-1:0] r_irq_status;
    logic [IO_W-1:0] r_irq_mask;
    logic [IO_W-1:0] r_edge_sel;
    logic            r_irq;
    logic [IO_W-1:0] w_edge;
    logic [IO_W-1:0] w_w1c;
`endif

    io_sync_edge #(
        .IO_W        (IO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_async    (io_in),
`ifdef IO_EDGE_IRQ_EN
        .i_edge_sel (r_edge_sel),
        .o_edge     (w_edge),
`endif
        .o_sync     (w_sync)
    );

    assign w_off   = wbs.wbs_adr_i[7:0];
    assign w_wdata = wbs.wbs_dat_i[IO_W-1:0];
    assign w_sel   = wbs.wbs_cyc_i && wbs.wbs_stb_i && (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_take  = (r_state == IDLE) && w_sel;
    assign w_wr    = w_take && wbs.wbs_we_i && wbs.wbs_sel_i[0];
    assign w_unused = &{1'b0, wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[DW-1:IO_W]};

    // Read mux; unmapped offsets read as zero
    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_DATA_OUT:   w_rd_data = DW'(r_data_out);
            OFF_OEB:        w_rd_data = DW'(r_oeb);
            OFF_DATA_IN:    w_rd_data = DW'(w_sync);
`ifdef IO_EDGE_IRQ_EN
            OFF_IRQ_STATUS: w_rd_data = DW'(r_irq_status);
            OFF_IRQ_MASK:   w_rd_data = DW'(r_irq_mask);
            OFF_EDGE_SEL:   w_rd_data = DW'(r_edge_sel);
`endif
            default:        w_rd_data = '0;
        endcase
    end

    // Bus FSM, register writes and read-data capture
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_data_out <= DATA_OUT_RST[IO_W-1:0];
            r_oeb      <= OEB_RST[IO_W-1:0];
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        if (!wbs.wbs_we_i) r_dat <= w_rd_data;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
            if (w_wr && (w_off == OFF_DATA_OUT)) r_data_out <= w_wdata;
            if (w_wr && (w_off == OFF_OEB))      r_oeb      <= w_wdata;
        end
    end

`ifdef IO_EDGE_IRQ_EN
    assign w_w1c = (w_wr && (w_off == OFF_IRQ_STATUS)) ? w_wdata : '0;

    // Edge set takes priority over a same-cycle W1C
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_status <= '0;
            r_irq_mask   <= '0;
            r_edge_sel   <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_irq_status <= (r_irq_status & ~w_w1c) | w_edge;
            r_irq        <= |(r_irq_status & r_irq_mask);
            if (w_wr && (w_off == OFF_IRQ_MASK)) r_irq_mask <= w_wdata;
            if (w_wr && (w_off == OFF_EDGE_SEL)) r_edge_sel <= w_wdata;
        end
    end

    assign user_irq = {2'b00, r_irq};
`else
    assign user_irq = 3'b000;
`endif

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign io_out        = r_data_out;
    assign io_oeb        = r_oeb;

endmodule
